// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one fixed-latency memory port between two requesters. Requester 0 is
// instruction fetch and only reads. Requester 1 is data load/store. The block
// arbitrates between them, latches the winner's command, counts off the memory
// latency, and then returns read data with a one-cycle completion pulse.
// Every output is registered.
//
// Configuration macro:
//   MEM_ARB_FIXED_PRIO_EN - when defined, requester 1 always wins a tie and
//                           `last` is ignored. When undefined, ties are
//                           resolved round-robin.
//
// Parameters:
//   ADDR_W - address width
//   DATA_W - data width
//   LAT    - memory latency in cycles (1..15)
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   req0_i       fetch request (level, held until gnt0_o)
//   addr0_i      fetch address
//   req1_i       data request (level, held until gnt1_o)
//   addr1_i      data address
//   we1_i        1 = store, 0 = load
//   wdata1_i     store data
//   gnt0_o       pulse: request 0 accepted
//   gnt1_o       pulse: request 1 accepted
//   valid0_o     pulse: access 0 complete, rdata_o valid
//   valid1_o     pulse: access 1 complete, rdata_o valid if load
//   rdata_o      captured read data
//   sel_o        current owner of the memory port (steering mux select)
//   busy_o       access in flight
//   mem_en_o     memory access enable
//   mem_we_o     memory write enable
//   mem_addr_o   memory address
//   mem_wdata_o  memory write data
//   mem_rdata_i  memory read data, valid LAT cycles after mem_en_o rises
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              we1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              valid0_o,
  output logic              valid1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sel_o,
  output logic              busy_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // The counter is loaded with LAT-1 so that the completion edge lands exactly
  // LAT cycles after the grant.
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              valid0_q, valid0_d;
  logic              valid1_q, valid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              any_req_s;
  logic              win_s;

  // Winner selection among the currently raised requests.
  always_comb begin
    any_req_s = req0_i | req1_i;
    if (req0_i && req1_i) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win_s = 1'b1;
`else
      win_s = ~last_q;
`endif
    end else if (req1_i) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and next-output logic for the IDLE/ACCESS sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    valid0_d    = 1'b0;
    valid1_d    = 1'b0;
    rdata_d     = rdata_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          gnt0_d   = ~win_s;
          gnt1_d   = win_s;
          sel_d    = win_s;
          busy_d   = 1'b1;
          mem_en_d = 1'b1;
          if (win_s) begin
            mem_addr_d  = addr1_i;
            mem_we_d    = we1_i;
            mem_wdata_d = wdata1_i;
          end else begin
            // Fetch never writes; the previous write data is simply held.
            mem_addr_d = addr0_i;
            mem_we_d   = 1'b0;
          end
          cnt_d   = CNT_INIT;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // A store completes without touching the captured read data.
          if (sel_q && mem_we_q) begin
            rdata_d = rdata_q;
          end else begin
            rdata_d = mem_rdata_i;
          end
          valid0_d = ~sel_q;
          valid1_d = sel_q;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          busy_d   = 1'b0;
          last_d   = sel_q;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      rdata_q     <= '0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      rdata_q     <= rdata_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign valid0_o    = valid0_q;
  assign valid1_o    = valid1_q;
  assign rdata_o     = rdata_q;
  assign sel_o       = sel_q;
  assign busy_o      = busy_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. It drives one LAT=2 instance and one
// LAT=1 instance, and every expected value is written out by hand.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;

  // LAT=2 instance signals
  logic        req0, req1, we1;
  logic [31:0] addr0, addr1, wdata1, mem_rdata;
  logic        gnt0, gnt1, valid0, valid1, sel, busy, mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  // LAT=1 instance signals
  logic        l_req0, l_req1, l_we1;
  logic [31:0] l_addr0, l_addr1, l_wdata1, l_mem_rdata;
  logic        l_gnt0, l_gnt1, l_valid0, l_valid1, l_sel, l_busy, l_mem_en, l_mem_we;
  logic [31:0] l_rdata, l_mem_addr, l_mem_wdata;

  int n_tests;
  int n_fail;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .addr0_i(addr0),
    .req1_i(req1), .addr1_i(addr1), .we1_i(we1), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .valid0_o(valid0), .valid1_o(valid1),
    .rdata_o(rdata), .sel_o(sel), .busy_o(busy),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .req0_i(l_req0), .addr0_i(l_addr0),
    .req1_i(l_req1), .addr1_i(l_addr1), .we1_i(l_we1), .wdata1_i(l_wdata1),
    .gnt0_o(l_gnt0), .gnt1_o(l_gnt1), .valid0_o(l_valid0), .valid1_o(l_valid1),
    .rdata_o(l_rdata), .sel_o(l_sel), .busy_o(l_busy),
    .mem_en_o(l_mem_en), .mem_we_o(l_mem_we), .mem_addr_o(l_mem_addr),
    .mem_wdata_o(l_mem_wdata), .mem_rdata_i(l_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_w;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata1 = 32'h0; mem_rdata = 32'h0;
    l_req0 = 1'b0; l_req1 = 1'b0; l_we1 = 1'b0;
    l_addr0 = 32'h0; l_addr1 = 32'h0; l_wdata1 = 32'h0; l_mem_rdata = 32'h0;

    // ---------------- reset ----------------
    tick();
    tick();
    check_eq("rst_outs", {gnt0, gnt1, valid0, valid1, sel, busy, mem_en, mem_we}, 64'h0);
    check_eq("rst_addr", mem_addr, 64'h0);
    check_eq("rst_rdata", rdata, 64'h0);
    rst = 1'b0;

    // ---------------- single fetch ----------------
    req0 = 1'b1; addr0 = 32'h100; mem_rdata = 32'hDEADBEEF;
    tick();
    check_eq("f_gnt0", gnt0, 64'h1);
    check_eq("f_gnt1", gnt1, 64'h0);
    check_eq("f_sel", sel, 64'h0);
    check_eq("f_addr", mem_addr, 64'h100);
    check_eq("f_en_busy_we", {mem_en, busy, mem_we}, 64'h6);
    req0 = 1'b0;
    tick();
    check_eq("f_mid", {gnt0, valid0, busy}, 64'h1);
    tick();
    check_eq("f_valid0", valid0, 64'h1);
    check_eq("f_rdata", rdata, 64'hDEADBEEF);
    check_eq("f_done", {busy, mem_en}, 64'h0);
    tick();
    check_eq("f_after", {valid0, busy}, 64'h0);

    // ---------------- store ----------------
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h55AA; mem_rdata = 32'h12345678;
    tick();
    check_eq("s_gnt", {gnt0, gnt1}, 64'h1);
    check_eq("s_sel_we", {sel, mem_we}, 64'h3);
    check_eq("s_wdata", mem_wdata, 64'h55AA);
    check_eq("s_addr", mem_addr, 64'h200);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    check_eq("s_hold", {gnt1, mem_we, sel}, 64'h3);
    check_eq("s_hold_wdata", mem_wdata, 64'h55AA);
    tick();
    check_eq("s_valid1", {valid0, valid1}, 64'h1);
    check_eq("s_rdata_kept", rdata, 64'hDEADBEEF);
    check_eq("s_we_off", mem_we, 64'h0);

    // ---------------- contention: 8 accesses ----------------
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0;
    addr0 = 32'h1000; addr1 = 32'h2000; mem_rdata = 32'h0BADF00D;
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_w = 1'b1;
`else
      exp_w = i[0];
`endif
      tick();
      check_eq($sformatf("c_gnt_%0d", i), {gnt0, gnt1}, {62'h0, ~exp_w, exp_w});
      check_eq($sformatf("c_sel_%0d", i), sel, {63'h0, exp_w});
      if (i == 7) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      check_eq($sformatf("c_gap_%0d", i), {gnt0, gnt1, valid0, valid1}, 64'h0);
      tick();
      check_eq($sformatf("c_valid_%0d", i), {gnt0, gnt1, valid0, valid1},
               {60'h0, 2'b00, ~exp_w, exp_w});
    end

    // ---------------- reset mid-access ----------------
    req0 = 1'b1; addr0 = 32'h300;
    tick();
    check_eq("r_gnt0", gnt0, 64'h1);
    req0 = 1'b0; rst = 1'b1;
    tick();
    check_eq("r_outs", {gnt0, gnt1, valid0, valid1, sel, busy, mem_en, mem_we}, 64'h0);
    check_eq("r_rdata", rdata, 64'h0);
    check_eq("r_addr", mem_addr, 64'h0);
    rst = 1'b0;
    tick();
    check_eq("r_no_valid", {valid0, valid1, busy}, 64'h0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h304; mem_rdata = 32'hCAFEF00D;
    tick();
    check_eq("r_gnt1", {gnt0, gnt1}, 64'h1);
    check_eq("r_addr1", mem_addr, 64'h304);
    req1 = 1'b0;
    tick();
    tick();
    check_eq("r_valid1", valid1, 64'h1);
    check_eq("r_load_rdata", rdata, 64'hCAFEF00D);

    // ---------------- late request during access ----------------
    req0 = 1'b1; addr0 = 32'h400; mem_rdata = 32'h11112222;
    tick();
    check_eq("l_gnt0", gnt0, 64'h1);
    req0 = 1'b0;
    tick();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h500; wdata1 = 32'h7777;
    tick();
    check_eq("l_valid0", {valid0, gnt1}, 64'h2);
    check_eq("l_rdata", rdata, 64'h11112222);
    tick();
    check_eq("l_gnt1", {gnt0, gnt1, valid0}, 64'h2);
    check_eq("l_wdata", mem_wdata, 64'h7777);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    tick();
    check_eq("l_valid1", valid1, 64'h1);
    check_eq("l_rdata_kept", rdata, 64'h11112222);

    // ---------------- LAT=1 instance ----------------
    l_req0 = 1'b1; l_addr0 = 32'h800; l_mem_rdata = 32'hA5A5A5A5;
    tick();
    check_eq("l1_gnt0", {l_gnt0, l_busy, l_mem_en}, 64'h7);
    check_eq("l1_addr", l_mem_addr, 64'h800);
    tick();
    check_eq("l1_valid0", {l_gnt0, l_valid0}, 64'h1);
    check_eq("l1_rdata", l_rdata, 64'hA5A5A5A5);
    l_mem_rdata = 32'h5A5A5A5A;
    tick();
    check_eq("l1_gnt0_again", {l_gnt0, l_valid0}, 64'h2);
    l_req0 = 1'b0;
    tick();
    check_eq("l1_valid0_again", {l_gnt0, l_valid0, l_busy}, 64'h2);
    check_eq("l1_rdata2", l_rdata, 64'h5A5A5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
